psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
- Two-port round-robin arbiter sharing the single PSRAM memory controller (16-bit word, 24-bit address, strobe/ready interface) between two requesters, e.g. the self-test sequencer and a frame/data engine.
- Converts each port's level request into one controller strobe, waits for completion and returns a one-cycle ack with read data.
- Adds a watchdog that flags a controller hang.

Parameters:
- ADDR_W, 24, address width presented to the controller.
- DATA_W, 16, data word width.
- TIMEOUT, 4096, max cycles in WAIT before the watchdog fires; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock (PLL output, 120 MHz nominal)
- resetn  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 request level; hold with p0_we/p0_addr/p0_wdata stable until p0_ack
- p0_we  in  1  1=write, 0=read
- p0_addr  in  ADDR_W  word address
- p0_wdata  in  DATA_W  write data
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  DATA_W  read data, valid from p0_ack cycle, held until next port-0 read completes
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0 for port 1
- mem_ready  in  1  controller idle/done
- mem_addr  out  ADDR_W  to controller
- mem_read_strb  out  1  one-cycle read strobe
- mem_write_strb  out  1  one-cycle write strobe
- mem_data_in  out  DATA_W  write data to controller
- mem_data_out  in  DATA_W  read data from controller
- busy  out  1  high in any state except IDLE
- grant  out  1  port currently owned (valid while busy)
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, resetn=0): state=IDLE.
  - All strobes, acks, busy, timeout_err = 0.
  - grant=0, last-served pointer=1 (port 0 wins first tie).
  - rdata regs, mem_addr, mem_data_in = 0.
  - Counter = 0.
- IDLE:
  - Stays while mem_ready=0 (covers controller power-up init of ~150 us) or no req.
  - Otherwise selects a port:
    - Only one port requesting: that port.
    - Both requesting: port != last-served.
  - Latches that port's we/addr/wdata into mem_addr/mem_data_in, sets grant, and goes to ISSUE.
- ISSUE (1 cycle):
  - Asserts mem_write_strb if we=1, else mem_read_strb; exactly one strobe, exactly one cycle.
  - Updates last-served = grant.
  - Goes to GUARD.
- GUARD (1 cycle): mem_ready ignored, because the controller drops ready only the cycle after the strobe. Clears the counter and goes to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If mem_ready=1: for a read, capture mem_data_out into the granted port's rdata; go to DONE.
  - If counter reaches TIMEOUT-1 with mem_ready=0: set timeout_err, go to DONE. rdata is not updated.
- DONE (1 cycle): pulse granted port's ack; go to IDLE.
- Latency and throughput:
  - req to ack is 4 cycles minimum (IDLE, ISSUE, GUARD, WAIT seeing ready), plus controller busy time.
  - Next grant can come the cycle after DONE.
- Requester rules:
  - A req still high in the cycle after ack is a new request.
  - Deasserting req before ack is illegal; the latched transaction completes regardless.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- Signal stability: mem_addr and mem_data_in are stable from ISSUE through DONE.
- The non-granted port's ack and rdata are untouched.
- Async reset mid-transaction returns everything to reset values immediately. No strobe is emitted on release until a fresh IDLE decision.
- timeout_err clears only on reset. The arbiter keeps operating after a timeout.

Test Plan:
- Single write then read on port 0: write addr 0x000000 data 0x1234, then read addr 0x000000, with controller model ready low for 20 cycles after each strobe. Expect:
  - One mem_write_strb with mem_data_in=0x1234.
  - One mem_read_strb.
  - p0_ack twice, p0_rdata=0x1234.
  - Strobe-to-ack = 22 cycles.
- Simultaneous requests after reset: p0 and p1 both read (addr 0x2, 0x4) in the same cycle. Expect port 0 granted first, then port 1, and each ack exactly once. p1_rdata equals model data at 0x4; p0_rdata is not disturbed by p1's read.
- Fairness: both ports hold req for 8 transactions each. Expect grant sequence 0,1,0,1,..., 16 strobes total, no back-to-back grants to one port.
- Power-up gating: mem_ready=0 for 18000 cycles with p1_req=1. Expect no strobe until ready rises, then p1 is served.
- Watchdog: TIMEOUT=64, model never re-asserts ready after a strobe. Expect:
  - timeout_err=1 at cycle 64 of WAIT, and ack pulsed.
  - Flag persists through a following successful transaction.
  - Flag clears on resetn=0.
- Reset mid-operation: assert resetn=0 during WAIT of a port-1 write, then release. Expect busy=0, no ack, no strobe until req is re-sampled, and first tie after release goes to port 0.

Source files
------------

// File: rtl/psram_arbiter_if.sv
// Requester and controller signal bundle for psram_arbiter.
// Handshake: req is a level held with we/addr/wdata stable until the one-cycle ack; strobes are one-cycle and mem_ready re-rising marks completion.
interface psram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_strb;
  logic              mem_write_strb;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    output mem_ready, mem_data_out,
    input  mem_addr, mem_read_strb, mem_write_strb, mem_data_in
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    input  mem_ready, mem_data_out,
    output mem_addr, mem_read_strb, mem_write_strb, mem_data_in
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter in front of a single PSRAM controller, with a
// watchdog on the completion wait.
module psram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               resetn,
  psram_arbiter_if.slave     bus,
  output logic               busy,
  output logic               grant,
  output logic               timeout_err,
  output logic [2:0]         state_dbg
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              last;
  logic              pick;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              wd_fire;

  assign wd_fire = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    pick               = bus.p1_req;
    bus.mem_read_strb  = 1'b0;
    bus.mem_write_strb = 1'b0;
    bus.p0_ack         = 1'b0;
    bus.p1_ack         = 1'b0;
    busy               = (state != S_IDLE);
    // On a tie, serve the port that did not go last.
    if (bus.p0_req && bus.p1_req) pick = ~last;
    case (state)
      S_IDLE: begin
        if (bus.mem_ready && (bus.p0_req || bus.p1_req)) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mem_write_strb = we_q;
        bus.mem_read_strb  = ~we_q;
        state_nxt          = S_GUARD;
      end
      S_GUARD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ready || wd_fire) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.p0_ack = ~grant;
        bus.p1_ack = grant;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant       <= 1'b0;
      last        <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (state_nxt == S_ISSUE) begin
            grant   <= pick;
            we_q    <= pick ? bus.p1_we    : bus.p0_we;
            addr_q  <= pick ? bus.p1_addr  : bus.p0_addr;
            wdata_q <= pick ? bus.p1_wdata : bus.p0_wdata;
          end
        end
        S_ISSUE: last <= grant;
        S_GUARD: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A timed-out read leaves the port's previous data in place.
          if (bus.mem_ready) begin
            if (!we_q) begin
              if (grant) rdata1 <= bus.mem_data_out;
              else       rdata0 <= bus.mem_data_out;
            end
          end else if (wd_fire) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.p0_rdata    = rdata0;
  assign bus.p1_rdata    = rdata1;
  assign state_dbg       = state;
endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: behavioural PSRAM controller, reference arbitration
// model and scoreboard, directed scenarios plus randomized two-port traffic.
module tb_psram_arbiter;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       busy, grant, timeout_err;
  logic [2:0] state_dbg;

  psram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  psram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy), .grant(grant),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_pat(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5a5a;
  endfunction

  // ---------------- controller model + scoreboard state ----------------
  logic [DATA_W-1:0] cmem [int];
  logic [DATA_W-1:0] gmem [int];
  int unsigned left = 0;
  int unsigned last_delay = 0;
  int unsigned delay_cfg = 20;
  bit rnd_delay = 0, hold = 0, hang = 0;

  logic              cur_we [2];
  logic [ADDR_W-1:0] cur_addr [2];
  logic [DATA_W-1:0] cur_wdata [2];

  int cyc = 0, strb_cyc = 0, n_strb = 0;
  int ack_cnt [2] = '{0, 0};
  int grant_q [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] hold_rd [2] = '{16'h0, 16'h0};
  bit inflight = 0, infl_port = 0, infl_we = 0, infl_hang = 0;
  int unsigned infl_delay = 0;
  bit last_served = 1, exp_to = 0, prev_ready = 0;
  bit prev_req [2] = '{0, 0};

  // Controller: ready low for the chosen delay after each strobe, memory updated at the strobe.
  task automatic ctl_step();
    if (!hang && left > 1000) left = 0;
    if (left > 0) begin
      bus.mem_ready = 1'b0;
      left--;
    end else begin
      bus.mem_ready = !hold;
    end
    if (bus.mem_write_strb || bus.mem_read_strb) begin
      int a = int'(bus.mem_addr);
      if (bus.mem_write_strb) cmem[a] = bus.mem_data_in;
      else bus.mem_data_out = cmem.exists(a) ? cmem[a] : init_pat(bus.mem_addr);
      last_delay = rnd_delay ? $urandom_range(1, 12) : delay_cfg;
      left = hang ? 32'h7fff_ffff : last_delay;
    end
  endtask

  task automatic mon_step();
    cyc++;
    if (!resetn) begin
      inflight = 0; last_served = 1; exp_to = 0; prev_ready = 0;
      hold_rd[0] = '0; hold_rd[1] = '0; prev_req[0] = 0; prev_req[1] = 0;
      exp_q.delete();
      return;
    end
    if (bus.mem_write_strb || bus.mem_read_strb) begin
      bit ep;
      int a;
      check("strb_excl", 32'(bus.mem_write_strb & bus.mem_read_strb), 0);
      check("strb_idle", 32'(inflight), 0);
      check("strb_req", 32'(prev_req[0] | prev_req[1]), 1);
      check("strb_ready", 32'(prev_ready), 1);
      ep = (prev_req[0] && prev_req[1]) ? !last_served : prev_req[1];
      check("grant", 32'(grant), 32'(ep));
      check("busy_issue", 32'(busy), 1);
      check("strb_we", 32'(bus.mem_write_strb), 32'(cur_we[ep]));
      check("strb_addr", 32'(bus.mem_addr), 32'(cur_addr[ep]));
      if (cur_we[ep]) check("strb_wdata", 32'(bus.mem_data_in), 32'(cur_wdata[ep]));
      check("to_before", 32'(timeout_err), 32'(exp_to));
      a = int'(cur_addr[ep]);
      last_served = ep;
      grant_q.push_back(int'(ep));
      n_strb++;
      inflight = 1; infl_port = ep; infl_we = cur_we[ep];
      infl_hang = hang; infl_delay = last_delay; strb_cyc = cyc;
      exp_q.delete();
      if (cur_we[ep]) gmem[a] = cur_wdata[ep];
      else exp_q.push_back(gmem.exists(a) ? gmem[a] : init_pat(cur_addr[ep]));
    end
    if (bus.p0_ack || bus.p1_ack) begin
      bit ap;
      ap = bus.p1_ack;
      check("ack_excl", 32'(bus.p0_ack & bus.p1_ack), 0);
      check("ack_inflight", 32'(inflight), 1);
      check("ack_port", 32'(ap), 32'(infl_port));
      check("ack_lat", 32'(cyc - strb_cyc), infl_hang ? 32'(TIMEOUT + 2) : 32'(infl_delay + 2));
      check("busy_done", 32'(busy), 1);
      check("addr_stable", 32'(bus.mem_addr), 32'(cur_addr[ap]));
      if (infl_we) check("wdata_stable", 32'(bus.mem_data_in), 32'(cur_wdata[ap]));
      if (infl_hang) exp_to = 1;
      else if (!infl_we && exp_q.size() > 0) hold_rd[ap] = exp_q.pop_front();
      check("p0_rdata", 32'(bus.p0_rdata), 32'(hold_rd[0]));
      check("p1_rdata", 32'(bus.p1_rdata), 32'(hold_rd[1]));
      check("timeout_err", 32'(timeout_err), 32'(exp_to));
      inflight = 0;
      ack_cnt[ap]++;
    end
    prev_req[0] = bus.p0_req;
    prev_req[1] = bus.p1_req;
    prev_ready  = bus.mem_ready;
  endtask

  always @(negedge clk) begin
    ctl_step();
    mon_step();
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input bit r, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cur_we[p] = we; cur_addr[p] = a; cur_wdata[p] = d;
    if (p == 0) begin
      bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  // Called just after a rising edge; returns just after the edge following the ack, req still high.
  task automatic txn(input int p, input bit we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input int budget);
    int base;
    bit ok;
    base = ack_cnt[p];
    ok = 0;
    set_req(p, 1'b1, we, a, d);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (ack_cnt[p] != base) begin
        ok = 1;
        break;
      end
    end
    check("drv_wait", 32'(ok), 1);
    #1;
  endtask

  task automatic idle(input int p);
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_strb", 32'({bus.mem_read_strb, bus.mem_write_strb}), 0);
    check("rst_ack", 32'({bus.p0_ack, bus.p1_ack}), 0);
    check("rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_data_in), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic rand_port(input int p, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      txn(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom), 200);
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        idle(p);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    idle(p);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int b0, b1, bs, gl, bad;
    idle(0);
    idle(1);
    do_reset();

    // single write then read on port 0
    @(posedge clk); #1;
    delay_cfg = 20; rnd_delay = 0;
    b0 = ack_cnt[0]; bs = n_strb;
    txn(0, 1'b1, 24'h000000, 16'h1234, 200); idle(0);
    txn(0, 1'b0, 24'h000000, 16'h0000, 200); idle(0);
    check("t1_acks", 32'(ack_cnt[0] - b0), 2);
    check("t1_strobes", 32'(n_strb - bs), 2);
    check("t1_rdata", 32'(bus.p0_rdata), 32'h1234);

    // simultaneous reads right after reset: port 0 first
    do_reset();
    gl = grant_q.size(); b0 = ack_cnt[0]; b1 = ack_cnt[1];
    fork
      begin txn(0, 1'b0, 24'h2, 16'h0, 200); idle(0); end
      begin txn(1, 1'b0, 24'h4, 16'h0, 200); idle(1); end
    join
    check("t2_first", 32'(grant_q[gl]), 0);
    check("t2_second", 32'(grant_q[gl + 1]), 1);
    check("t2_acks", 32'((ack_cnt[0] - b0) * 16 + (ack_cnt[1] - b1)), 32'h11);
    check("t2_p1_rdata", 32'(bus.p1_rdata), 32'(init_pat(24'h4)));
    check("t2_p0_rdata", 32'(bus.p0_rdata), 32'(init_pat(24'h2)));

    // fairness under continuous demand
    rnd_delay = 1;
    gl = grant_q.size(); b0 = ack_cnt[0]; b1 = ack_cnt[1];
    fork
      rand_port(0, 8, 0);
      rand_port(1, 8, 0);
    join
    bad = 0;
    for (int i = gl + 1; i < grant_q.size(); i++)
      if (grant_q[i] == grant_q[i - 1]) bad++;
    check("fair_alternate", 32'(bad), 0);
    check("fair_strobes", 32'(grant_q.size() - gl), 16);
    check("fair_acks", 32'((ack_cnt[0] - b0) * 16 + (ack_cnt[1] - b1)), 32'h88);

    // randomized traffic with gaps
    b0 = ack_cnt[0]; b1 = ack_cnt[1];
    fork
      rand_port(0, 20, 4);
      rand_port(1, 20, 4);
    join
    check("rand_acks0", 32'(ack_cnt[0] - b0), 20);
    check("rand_acks1", 32'(ack_cnt[1] - b1), 20);

    // power-up gating: no strobe while ready is held low
    rnd_delay = 0; delay_cfg = 5;
    bs = n_strb; b1 = ack_cnt[1];
    hold = 1;
    fork
      begin txn(1, 1'b0, 24'h6, 16'h0, 20000); idle(1); end
      begin
        repeat (18000) @(posedge clk);
        check("pwr_no_strobe", 32'(n_strb), 32'(bs));
        hold = 0;
      end
    join
    check("pwr_served", 32'(ack_cnt[1] - b1), 1);

    // watchdog: controller never comes back
    hang = 1;
    txn(0, 1'b0, 24'h3, 16'h0, 200); idle(0);
    hang = 0;
    check("wd_flag", 32'(timeout_err), 1);
    txn(1, 1'b1, 24'h5, 16'hbeef, 200); idle(1);
    check("wd_sticky", 32'(timeout_err), 1);
    do_reset();
    check("wd_cleared", 32'(timeout_err), 0);

    // reset in the middle of a port-1 write
    delay_cfg = 20;
    @(posedge clk); #1;
    bs = n_strb; b1 = ack_cnt[1];
    set_req(1, 1'b1, 1'b1, 24'h9, 16'h5555);
    for (int i = 0; i < 50 && n_strb == bs; i++) @(posedge clk);
    check("mid_strobe_seen", 32'(n_strb - bs), 1);
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_vals();
    idle(1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_strobe", 32'(n_strb - bs), 1);
    check("mid_no_ack", 32'(ack_cnt[1] - b1), 0);
    check("mid_busy", 32'(busy), 0);
    gl = grant_q.size();
    fork
      begin txn(0, 1'b0, 24'ha, 16'h0, 200); idle(0); end
      begin txn(1, 1'b0, 24'hb, 16'h0, 200); idle(1); end
    join
    check("mid_tie_p0", 32'(grant_q[gl]), 0);

    repeat (5) @(posedge clk);
    check("end_idle", 32'(inflight), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
